prog_loader: RTL
================

Name: prog_loader

Overview:
- External-side master for the CPU's halt/external-RAM port.
- Receives a byte stream (length header, then program words) and asserts HALT.
- Writes each word into RAM through ADDRESS/BUS/EXT_RAM_RW/EXT_RAM_EN, optionally reads it back to verify, then releases HALT so the CPU runs the loaded image.
- Sits between a host byte source (UART receiver or testbench) and the CPU top-level.

Parameters:
- BASE_ADDR, 16'h0000, RAM address of the first loaded word.
- VERIFY, 1, 1 = read back and compare every word after writing it; 0 = write only.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle load request; honoured only in IDLE.
- BYTE_DATA  input  8  incoming stream byte.
- BYTE_VALID  input  1  BYTE_DATA is valid.
- BYTE_READY  output  1  loader accepts a byte this cycle.
- HALT  output  1  stops the CPU controller and hands RAM control to this block.
- ADDRESS  output  16  RAM address.
- EXT_RAM_RW  output  1  1 = write (loader drives BUS), 0 = read (RAM drives BUS).
- EXT_RAM_EN  output  1  RAM access enable.
- BUS  inout  16  shared data bus; driven only in WRITE, high-Z otherwise.
- DONE  output  1  one-cycle pulse on successful completion.
- ERROR  output  1  sticky verify-mismatch flag.
- WORDS_LOADED  output  16  count of words written in the current or last load.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - HALT=0, BYTE_READY=0, EXT_RAM_EN=0, EXT_RAM_RW=0, ADDRESS=BASE_ADDR.
  - BUS high-Z, DONE=0, ERROR=0, WORDS_LOADED=0, state IDLE.
- Reset mid-operation aborts the load immediately. HALT drops asynchronously. No partial-write recovery is attempted.
- Byte handshake: a byte transfers on a rising edge with BYTE_VALID=1 and BYTE_READY=1. BYTE_READY is 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- Stream format (big-endian): LEN[15:8], LEN[7:0], then LEN words, each sent high byte then low byte.
- States and transitions:
  - IDLE: START=1 → SETUP. ERROR is cleared and WORDS_LOADED is zeroed on that edge. START in any other state is ignored.
  - SETUP: HALT=1 for one cycle so the controller freezes before any RAM access → LEN_HI.
  - LEN_HI, LEN_LO: capture the length. After LEN_LO, go to DONE if LEN=0, else to DATA_HI. ADDRESS=BASE_ADDR.
  - DATA_HI → DATA_LO: assemble the 16-bit word.
  - WRITE (1 cycle): EXT_RAM_EN=1, EXT_RAM_RW=1, BUS=word; RAM latches on the closing edge. WORDS_LOADED increments on that edge. Next state is READ if VERIFY=1, else NEXT.
  - READ (2 cycles): EXT_RAM_EN=1, EXT_RAM_RW=0, BUS released. BUS is sampled at the end of the 2nd cycle. Mismatch → FAIL; match → NEXT.
  - NEXT: decrement the remaining count and increment ADDRESS (mod 2^16, wrap from 16'hFFFF to 16'h0000 silently). Go to DONE if remaining=0, else DATA_HI.
  - DONE: DONE=1 for one cycle; HALT=0 from the following cycle → IDLE.
  - FAIL: ERROR=1 and HALT held at 1 (CPU stays stopped on a bad image) → IDLE with HALT=1. HALT remains 1 until the next START completes or RST is asserted.
- HALT stays 1 continuously from SETUP through DONE. EXT_RAM_EN is never 1 while HALT=0.
- Bus turnaround: BUS goes high-Z in the same cycle EXT_RAM_RW falls. The loader never drives BUS in the cycle after a READ.
- Per-word cost with no stream stalls: 2 byte cycles + 1 (WRITE) + 2 (READ, VERIFY=1) + 1 (NEXT).
- BYTE_VALID low stalls the FSM indefinitely in the byte states, with no timeout. RAM signals remain inactive while stalled.

Test Plan:
- Reset during a write → with RST held low across a WRITE cycle, HALT=0, BUS high-Z and EXT_RAM_EN=0 within the same cycle; after release the FSM is in IDLE and DONE never pulses.
- Basic load (VERIFY=1, BASE_ADDR=0x0010) → START then bytes 00 02 12 34 AB CD:
  - RAM[0x0010]=0x1234 and RAM[0x0011]=0xABCD.
  - WORDS_LOADED=2, one DONE pulse, ERROR=0.
  - HALT high from SETUP until the cycle after DONE.
- Zero-length load → bytes 00 00: no EXT_RAM_EN activity, DONE pulses, WORDS_LOADED=0, HALT released.
- Verify failure → RAM model forces a read of 0x0000 for a written 0x5555: ERROR=1, no DONE pulse, HALT stays 1. A following START clears ERROR.
- Address wrap (BASE_ADDR=0xFFFF) → 2 words 0x0001, 0x0002 land at 0xFFFF and 0x0000.
- Stalled stream and ignored START (VERIFY=0) → BYTE_VALID deasserted for 10 cycles between the hi and lo bytes:
  - The FSM holds with EXT_RAM_EN=0.
  - A START pulse during the stall is ignored.
  - The load completes correctly with exactly 1 WRITE cycle per word and no READ cycles.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed word image into external RAM.
// Holds the CPU in HALT while words are written and optionally read back.
module prog_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter bit          VERIFY    = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [7:0]  BYTE_DATA,
   input  logic        BYTE_VALID,
   output logic        BYTE_READY,
   output logic        HALT,
   output logic [15:0] ADDRESS,
   output logic        EXT_RAM_RW,
   output logic        EXT_RAM_EN,
   inout  wire  [15:0] BUS,
   output logic        DONE,
   output logic        ERROR,
   output logic [15:0] WORDS_LOADED
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_READ,
      S_NEXT,
      S_DONE,
      S_FAIL
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] word_q, word_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        hold_q, hold_d;
   logic        rd2_q, rd2_d;
   logic        bus_oe;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         len_q   <= 16'h0000;
         word_q  <= 16'h0000;
         addr_q  <= BASE_ADDR;
         cnt_q   <= 16'h0000;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
         rd2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
         rd2_q   <= rd2_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_d     = word_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      hold_d     = hold_q;
      rd2_d      = 1'b0;
      BYTE_READY = 1'b0;
      EXT_RAM_EN = 1'b0;
      EXT_RAM_RW = 1'b0;
      bus_oe     = 1'b0;
      DONE       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_SETUP;
               err_d   = 1'b0;
               cnt_d   = 16'h0000;
               hold_d  = 1'b0;
               addr_d  = BASE_ADDR;
            end
         end
         // one cycle of HALT before any RAM access
         S_SETUP: state_d = S_LEN_HI;
         S_LEN_HI: begin
            BYTE_READY = 1'b1;
            if (BYTE_VALID) begin
               len_d   = {BYTE_DATA, len_q[7:0]};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            BYTE_READY = 1'b1;
            if (BYTE_VALID) begin
               len_d   = {len_q[15:8], BYTE_DATA};
               state_d = ({len_q[15:8], BYTE_DATA} == 16'h0000)
                         ? S_DONE : S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            BYTE_READY = 1'b1;
            if (BYTE_VALID) begin
               word_d  = {BYTE_DATA, word_q[7:0]};
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            BYTE_READY = 1'b1;
            if (BYTE_VALID) begin
               word_d  = {word_q[15:8], BYTE_DATA};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            EXT_RAM_EN = 1'b1;
            EXT_RAM_RW = 1'b1;
            bus_oe     = 1'b1;
            cnt_d      = cnt_q + 16'd1;
            state_d    = VERIFY ? S_READ : S_NEXT;
         end
         // RAM data is trusted only at the end of the second read cycle
         S_READ: begin
            EXT_RAM_EN = 1'b1;
            rd2_d      = ~rd2_q;
            if (rd2_q) begin
               if (BUS == word_q) begin
                  state_d = S_NEXT;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_FAIL;
               end
            end
         end
         S_NEXT: begin
            len_d   = len_q - 16'd1;
            addr_d  = addr_q + 16'd1;
            state_d = (len_q == 16'd1) ? S_DONE : S_DATA_HI;
         end
         S_DONE: begin
            DONE    = 1'b1;
            state_d = S_IDLE;
         end
         // keep the CPU frozen on a bad image until a new load
         S_FAIL: begin
            hold_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign HALT         = (state_q != S_IDLE) || hold_q;
   assign ADDRESS      = addr_q;
   assign ERROR        = err_q;
   assign WORDS_LOADED = cnt_q;
   assign BUS          = bus_oe ? word_q : 16'hzzzz;

endmodule
